// File: rtl/eot_release_pkg.sv
// Shared types and the count-step helper for the release-after-EOT transmitter.
package eot_release_pkg;

  typedef enum logic {
    PASS    = 1'b0,
    RELEASE = 1'b1
  } state_t;

  // Default-width view of a din beat; the top uses W_DIN for its own slicing.
  localparam int unsigned DIN_W = 16;

  typedef struct packed {
    logic             eot;
    logic [DIN_W-2:0] data;
  } din_t;

  // cnt + 1, either wrapping (caller truncates) or clamped at max_val.
  function automatic logic [31:0] cnt_step(input logic [31:0] cnt,
                                           input logic [31:0] max_val,
                                           input logic        sat);
    if (sat && (cnt >= max_val)) return max_val;
    return cnt + 32'd1;
  endfunction

endpackage

// File: rtl/eot_release_gen_beat_counter.sv
// Beat counter with clear/increment and a look-ahead cnt+1 output.
// EOT_RELEASE_CNT_SAT_EN selects saturating instead of wrapping arithmetic.
module beat_counter
  import eot_release_pkg::*;
#(
  parameter int W_CNT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [W_CNT-1:0] cnt_o,
  output logic [W_CNT-1:0] nxt_o
);

`ifdef EOT_RELEASE_CNT_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  localparam logic [W_CNT-1:0] CNT_MAX = {W_CNT{1'b1}};

  logic [W_CNT-1:0] cnt_q, cnt_d;

  assign nxt_o = W_CNT'(cnt_step(32'(cnt_q), 32'(CNT_MAX), SAT));
  assign cnt_o = cnt_q;

  // Clear wins: the EOT beat loads rel_q from nxt_o and restarts at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = nxt_o;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/eot_release_gen.sv
// Forwards an EOT-terminated stream unchanged, then issues one release token
// carrying the beat count. Build with EOT_RELEASE_CNT_SAT_EN for saturating counts.
module eot_release_gen
  import eot_release_pkg::*;
#(
  parameter int W_DIN = 16,
  parameter int W_CNT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid_i,
  input  logic [W_DIN-1:0] din_data_i,
  output logic             din_ready_o,
  output logic             dout_valid_o,
  output logic [W_DIN-1:0] dout_data_o,
  input  logic             dout_ready_i,
  output logic             rel_valid_o,
  output logic [W_CNT-1:0] rel_data_o,
  input  logic             rel_ready_i
);

  state_t           state_q, state_d;
  logic [W_CNT-1:0] rel_q, rel_d;
  logic [W_CNT-1:0] cnt, cnt_nxt;
  logic             eot, beat_hs;

  assign eot     = din_data_i[W_DIN-1];
  assign beat_hs = (state_q == PASS) && din_valid_i && dout_ready_i;

  beat_counter #(.W_CNT(W_CNT)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (beat_hs && eot),
    .inc_i (beat_hs && !eot),
    .cnt_o (cnt),
    .nxt_o (cnt_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PASS;
      rel_q   <= '0;
    end else begin
      state_q <= state_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rel_d   = rel_q;
    case (state_q)
      PASS: begin
        if (beat_hs && eot) begin
          state_d = RELEASE;
          rel_d   = cnt_nxt;
        end
      end
      RELEASE: if (rel_ready_i) state_d = PASS;
      default: state_d = PASS;
    endcase
  end

  // rel_valid comes straight off the state register, so it never sees rel_ready.
  always_comb begin
    din_ready_o  = 1'b0;
    dout_valid_o = 1'b0;
    rel_valid_o  = 1'b0;
    case (state_q)
      PASS: begin
        din_ready_o  = dout_ready_i;
        dout_valid_o = din_valid_i;
      end
      RELEASE: rel_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign dout_data_o = din_data_i;
  assign rel_data_o  = rel_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_eot_release_gen.sv
// Directed + randomized bench for eot_release_gen against a transaction-level model.
module tb_eot_release_gen;
  localparam int W_DIN   = 16;
  localparam int W_CNT   = 3;
  localparam int CNT_MAX = (1 << W_CNT) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             din_valid = 1'b0;
  logic [W_DIN-1:0] din_data = '0;
  logic             din_ready;
  logic             dout_valid;
  logic [W_DIN-1:0] dout_data;
  logic             dout_ready = 1'b0;
  logic             rel_valid;
  logic [W_CNT-1:0] rel_data;
  logic             rel_ready = 1'b0;

  eot_release_gen #(.W_DIN(W_DIN), .W_CNT(W_CNT)) dut (
    .clk          (clk),
    .rst          (rst),
    .din_valid_i  (din_valid),
    .din_data_i   (din_data),
    .din_ready_o  (din_ready),
    .dout_valid_o (dout_valid),
    .dout_data_o  (dout_data),
    .dout_ready_i (dout_ready),
    .rel_valid_o  (rel_valid),
    .rel_data_o   (rel_data),
    .rel_ready_i  (rel_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: is a release token owed, beats so far, last reported count.
  bit m_rel    = 1'b0;
  int m_beats  = 0;
  int m_relval = 0;

  function automatic int rel_of(input int n);
`ifdef EOT_RELEASE_CNT_SAT_EN
    return (n > CNT_MAX) ? CNT_MAX : n;
`else
    return n % (CNT_MAX + 1);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit dv, input logic [W_DIN-1:0] d, input bit dr,
                      input bit rr, output bit acc);
    @(negedge clk);
    din_valid = dv; din_data = d; dout_ready = dr; rel_ready = rr;
    #1;
    check("dout_valid", 32'(dout_valid), 32'(dv && !m_rel));
    check("din_ready",  32'(din_ready),  32'(dr && !m_rel));
    check("dout_data",  32'(dout_data),  32'(d));
    check("rel_valid",  32'(rel_valid),  32'(m_rel));
    check("rel_data",   32'(rel_data),   32'(m_relval));
    acc = dv && dr && !m_rel;
    @(posedge clk);
    if (m_rel) begin
      if (rr) m_rel = 1'b0;
    end else if (acc) begin
      m_beats++;
      if (d[W_DIN-1]) begin
        m_relval = rel_of(m_beats);
        m_beats  = 0;
        m_rel    = 1'b1;
      end
    end
  endtask

  task automatic send_txn(input int n, input int mult, input int dr_pct, input int rr_pct,
                          input int hold_rr, input bit eot_last);
    bit acc, dr, rr;
    logic [W_DIN-1:0] d;
    for (int i = 0; i < n; i++) begin
      d   = {(eot_last && (i == n - 1)), 15'(mult * (i + 1))};
      acc = 1'b0;
      for (int t = 0; !acc; t++) begin
        if (t > 200) begin
          checks++; errors++;
          $error("FAIL beat_timeout: beat %0d not accepted, expected within 200 cycles", i);
          break;
        end
        dr = ($urandom_range(99) < dr_pct);
        rr = (i == 0 && t < hold_rr) ? 1'b0 : ($urandom_range(99) < rr_pct);
        step(1'b1, d, dr, rr, acc);
      end
    end
  endtask

  task automatic drain();
    bit acc;
    for (int t = 0; m_rel; t++) begin
      if (t > 50) begin
        checks++; errors++;
        $error("FAIL drain_timeout: release still pending, expected handshake");
        break;
      end
      step(1'b0, '0, 1'b1, 1'b1, acc);
    end
    step(1'b0, '0, 1'b1, 1'b1, acc);
  endtask

  task automatic async_reset();
    @(negedge clk);
    din_valid = 1'b0; dout_ready = 1'b1; rel_ready = 1'b0;
    #1 rst = 1'b0;
    #1;
    m_rel = 1'b0; m_beats = 0; m_relval = 0;
    check("rst_rel_valid",  32'(rel_valid),  32'd0);
    check("rst_rel_data",   32'(rel_data),   32'd0);
    check("rst_din_ready",  32'(din_ready),  32'd1);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
  endtask

  initial begin
    bit acc;
    // Reset state: dout.valid follows din.valid even while held in reset.
    din_valid = 1'b1; dout_ready = 1'b1;
    #2;
    check("reset_rel_valid",  32'(rel_valid),  32'd0);
    check("reset_rel_data",   32'(rel_data),   32'd0);
    check("reset_dout_valid", 32'(dout_valid), 32'd1);
    check("reset_din_ready",  32'(din_ready),  32'd1);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    din_valid = 1'b0;

    // 4-beat full-throughput transaction.
    send_txn(4, 'h11, 100, 100, 0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1, acc);
    step(1'b0, '0, 1'b1, 1'b1, acc);

    // Back-to-back single-beat transactions.
    send_txn(1, 'h5, 100, 100, 0, 1'b1);
    send_txn(1, 'h6, 100, 100, 0, 1'b1);
    drain();

    // rel.ready held low 10 cycles with the next beat waiting.
    send_txn(2, 'h21, 100, 100, 0, 1'b1);
    send_txn(1, 'h9, 100, 100, 10, 1'b1);
    drain();

    // 7 beats under 50% dout backpressure.
    send_txn(7, $urandom_range(1, 4000), 50, 100, 0, 1'b1);
    drain();

    // Count overflow: 9 beats on a 3-bit counter.
    send_txn(9, 'h3, 100, 100, 0, 1'b1);
    drain();

    // Async reset mid-RELEASE, then after beat 2 of a transaction.
    send_txn(3, 'h7, 100, 100, 0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, acc);
    async_reset();
    send_txn(2, 'h8, 100, 100, 0, 1'b0);
    async_reset();
    send_txn(3, 'hA, 100, 100, 0, 1'b1);
    drain();

    // Random transactions with random lengths and backpressure.
    for (int k = 0; k < 20; k++)
      send_txn($urandom_range(1, 12), $urandom_range(1, 2000), 70, 60, $urandom_range(0, 3), 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/eot_release_gen.md
# eot_release_gen

Transmitter side of the release-after-EOT handshake. Forwards an EOT-terminated `din` transaction to `dout` with zero latency, counting beats. After the EOT beat handshakes, it blocks `din` and issues a single release token on `rel` carrying the beat count. It re-arms once `rel` handshakes. It sits upstream of any block that gates its traffic on a predicate stream's EOT.

## Interface
Parameters:
- `W_DIN`, 16: `din`/`dout` data width; MSB is `eot`, the lower `W_DIN-1` bits are payload.
- `W_CNT`, 8: beat counter width and `rel` data width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `din`  dti.consumer  `W_DIN`  incoming transaction stream.
- `dout`  dti.producer  `W_DIN`  forwarded stream, data unchanged.
- `rel`  dti.producer  `W_CNT`  release token; data = beats in the completed transaction, EOT beat included.

## Operation
- FSM states: `PASS` and `RELEASE`. Reset state is `PASS`.
- In `PASS`:
  - `dout.data = din.data`, `dout.valid = din.valid`, `din.ready = dout.ready`.
  - `rel.valid = 0`.
  - A beat handshake (`din.valid && dout.ready`) with `eot = 0` sets `cnt <= cnt + 1`.
  - A beat handshake with `eot = 1` sets `rel_q <= cnt + 1`, `cnt <= 0`, and moves to `RELEASE`.
- In `RELEASE`:
  - `din.ready = 0`, `dout.valid = 0`, `rel.valid = 1`, `rel.data = rel_q`.
  - On `rel.ready`, return to `PASS`.
- Count arithmetic is modulo 2^`W_CNT` (see Configuration).
- A single-beat transaction (EOT on the first beat) yields `rel.data = 1`.
- `rel.valid` and `rel.data` are registered and never depend on `rel.ready`.
- `dout.valid` must not depend on `dout.ready`.
- Reset values: state `PASS`, `cnt = 0`, `rel_q = 0`, `rel.valid = 0`. `dout.valid` follows `din.valid`.

## Timing
- `din` to `dout`: combinational, 0 cycles.
- EOT handshake in cycle N gives `rel.valid = 1` from cycle N+1 until the `rel` handshake, inclusive.
- A `rel` handshake in cycle M lets `din` accept again from cycle M+1. The minimum gap between the EOT beat and the next transaction's first beat is one cycle.
- `din.valid` held during `RELEASE`: the beat is not consumed and must stay stable. This is the producer's obligation.
- `rel.ready` low: the FSM stalls in `RELEASE` indefinitely. No data is lost.
- Reset asserted mid-transaction or mid-`RELEASE`: state, `cnt` and `rel.valid` clear immediately, without waiting for a clock edge. A partial transaction's count is discarded.
- Reset deasserts synchronously to `clk` and is synchronised externally.

## Configuration
- Macro `EOT_RELEASE_CNT_SAT_EN`.
- Defined: `cnt` and `cnt + 1` saturate at 2^`W_CNT`-1. A transaction of 2^`W_CNT` or more beats reports 2^`W_CNT`-1.
- Undefined: wrap-around. 2^`W_CNT` beats reports 0; 2^`W_CNT`+1 beats reports 1.

## Structure
- Package `eot_release_pkg` holds:
  - the `state_t` enum (`PASS`, `RELEASE`);
  - a parameterised packed `din_t` struct with `eot` in the MSB and `data[W_DIN-2:0]`;
  - the saturation/wrap helper function.
- One sub-module, `beat_counter`, holds:
  - `cnt`, with clear and increment inputs;
  - a `nxt` output equal to `cnt + 1`;
  - the `EOT_RELEASE_CNT_SAT_EN` logic.
- The top level holds the FSM and `rel_q`.

## Test plan
- 4-beat transaction (payloads 0x11, 0x22, 0x33, 0x44 with EOT) at full throughput, `rel.ready = 1` -> `dout` carries identical beats with 0 latency; `rel.data = 4` one cycle after the EOT beat; `din.ready` is low for exactly 1 cycle.
- Single-beat EOT transaction followed by a back-to-back second one -> `rel.data = 1` twice; the second beat is stalled one cycle by `RELEASE`.
- `rel.ready` held low 10 cycles after EOT while `din.valid = 1` -> `din.ready = 0` and `dout.valid = 0` throughout; `rel.valid` and `rel.data` stay stable; the next beat is accepted the cycle after the `rel` handshake.
- Random `dout.ready` backpressure (50%) over a 7-beat transaction -> no beat dropped or duplicated; `rel.data = 7`.
- `W_CNT = 3`, 9-beat transaction -> `rel.data = 1` without the macro; `rel.data = 7` with `EOT_RELEASE_CNT_SAT_EN`.
- `rst` asserted asynchronously mid-`RELEASE` and after beat 2 of a transaction -> `rel.valid` drops the same cycle; the following 3-beat transaction reports `rel.data = 3`.
